// File: rtl/exe_mdu_pkg.sv
// Shared decode constants, state encoding and helpers for the iterative
// RV32M multiply/divide unit.
package exe_mdu_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_M        = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == INST_TYPE_R_M) && (funct7 == INST_M);
  endfunction

endpackage

// File: rtl/exe_mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module mdu_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  quot_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  assign shifted  = {rem, dividend_bit};
  assign diff     = shifted - {1'b0, divisor};
  // The remainder is always below the divisor, so a set top bit means a borrow.
  assign quot_bit = ~diff[DATA_WIDTH];
  assign rem_next = quot_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/exe_mdu.sv
// Iterative RV32M unit: one multiply/divide bit per cycle on operand magnitudes,
// sign fix-up at the end, one-cycle write-back strobe.
module exe_mdu
  import exe_mdu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   flush_i,
  input  logic [31:0]            inst_i,
  input  logic [DATA_WIDTH-1:0]  op1_i,
  input  logic [DATA_WIDTH-1:0]  op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONES     = {DATA_WIDTH{1'b1}};

  mdu_state_e state_reg, state_next;
  logic [2:0]              funct3_reg;
  logic [RADDR_WIDTH-1:0]  rd_reg;
  logic                    we_reg, neg_reg;
  logic [DATA_WIDTH-1:0]   opnd_reg;
  logic [2*DATA_WIDTH-1:0] acc_reg, acc_step;
  logic [CNT_WIDTH-1:0]    cnt_reg;
  logic                    valid_reg, valid_next, we_out_reg, we_out_next, load_result;
  logic [DATA_WIDTH-1:0]   wdata_reg, result_next;

  logic [2:0]            funct3;
  logic                  accept, op1_neg, op2_neg, neg_in, div_zero, div_ovf, fast_path;
  logic [DATA_WIDTH-1:0] mag1, mag2, fast_result;
  logic                  unused_inst;

  assign funct3      = inst_i[14:12];
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};
  assign busy_o      = (state_reg != MDU_IDLE);
  assign accept      = start_i && !busy_o && !flush_i && is_m_op(inst_i[6:0], inst_i[31:25]);

  assign op1_neg = op1_i[DATA_WIDTH-1] && (funct3 inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM});
  assign op2_neg = op2_i[DATA_WIDTH-1] && (funct3 inside {INST_MULH, INST_DIV, INST_REM});
  assign mag1    = op1_neg ? -op1_i : op1_i;
  assign mag2    = op2_neg ? -op2_i : op2_i;
  // MULHSU and REM take their result sign from op1 alone.
  assign neg_in  = (funct3 == INST_MULHSU || funct3 == INST_REM) ? op1_neg : (op1_neg ^ op2_neg);

  assign div_zero    = funct3[2] && (op2_i == '0);
  assign div_ovf     = (funct3 == INST_DIV || funct3 == INST_REM) && (op1_i == MIN_VAL) && (op2_i == ONES);
  assign fast_path   = div_zero || div_ovf;
  assign fast_result = div_zero ? (funct3[1] ? op1_i : ONES) : (funct3[1] ? '0 : MIN_VAL);

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH-1:0] div_rem;
  logic                  div_q;

  assign mul_sum = {1'b0, acc_reg[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + {1'b0, opnd_reg & {DATA_WIDTH{acc_reg[0]}}};

  mdu_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_div_step (
    .rem          (acc_reg[2*DATA_WIDTH-1:DATA_WIDTH]),
    .dividend_bit (acc_reg[DATA_WIDTH-1]),
    .divisor      (opnd_reg),
    .rem_next     (div_rem),
    .quot_bit     (div_q)
  );

  // Divide shifts the quotient in from the bottom; multiply shifts the product out.
  assign acc_step = funct3_reg[2] ? {div_rem, acc_reg[DATA_WIDTH-2:0], div_q}
                                  : {mul_sum, acc_reg[DATA_WIDTH-1:1]};

  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quot_fix, rem_fix, fix_result;

  assign prod_fix = neg_reg ? -acc_reg : acc_reg;
  assign quot_fix = neg_reg ? -acc_reg[DATA_WIDTH-1:0] : acc_reg[DATA_WIDTH-1:0];
  assign rem_fix  = neg_reg ? -acc_reg[2*DATA_WIDTH-1:DATA_WIDTH] : acc_reg[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    fix_result = quot_fix;
    if (!funct3_reg[2]) begin
      fix_result = (funct3_reg == INST_MUL) ? prod_fix[DATA_WIDTH-1:0]
                                            : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    end else if (funct3_reg[1]) begin
      fix_result = rem_fix;
    end
  end

  always_comb begin
    state_next  = state_reg;
    valid_next  = 1'b0;
    we_out_next = WRITE_DISABLE;
    load_result = 1'b0;
    result_next = fix_result;
    if (flush_i) begin
      state_next = MDU_IDLE;
    end else begin
      case (state_reg)
        MDU_IDLE: begin
          if (accept) begin
            if (fast_path) begin
              state_next  = MDU_DONE;
              valid_next  = 1'b1;
              we_out_next = (reg_we_i && reg_waddr_i != '0) ? WRITE_ENABLE : WRITE_DISABLE;
              load_result = 1'b1;
              result_next = fast_result;
            end else begin
              state_next = MDU_CALC;
            end
          end
        end
        MDU_CALC: if (cnt_reg == CNT_LAST) state_next = MDU_FIX;
        MDU_FIX: begin
          state_next  = MDU_DONE;
          valid_next  = 1'b1;
          we_out_next = (we_reg && rd_reg != '0) ? WRITE_ENABLE : WRITE_DISABLE;
          load_result = 1'b1;
        end
        MDU_DONE: state_next = MDU_IDLE;
        default:  state_next = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= MDU_IDLE;
      valid_reg  <= 1'b0;
      we_out_reg <= WRITE_DISABLE;
      wdata_reg  <= '0;
      funct3_reg <= '0;
      rd_reg     <= '0;
      we_reg     <= 1'b0;
      neg_reg    <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      valid_reg  <= valid_next;
      we_out_reg <= we_out_next;
      if (load_result) wdata_reg <= result_next;
      if (accept) begin
        funct3_reg <= funct3;
        rd_reg     <= reg_waddr_i;
        we_reg     <= reg_we_i;
        neg_reg    <= neg_in;
        opnd_reg   <= funct3[2] ? mag2 : mag1;
        acc_reg    <= {{DATA_WIDTH{1'b0}}, funct3[2] ? mag1 : mag2};
        cnt_reg    <= '0;
      end else if (state_reg == MDU_CALC) begin
        acc_reg <= acc_step;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign valid_o     = valid_reg;
  assign reg_we_o    = we_out_reg;
  assign reg_waddr_o = rd_reg;
  assign reg_wdata_o = wdata_reg;

endmodule
